imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Pipelined, parametrised immediate generator for the RV_CORE decode path. It accepts raw 32-bit instructions over a valid/ready handshake and classifies each one from its opcode. It produces the sign-extended XLEN-wide immediate, the instruction format and an illegal-opcode flag, one cycle later. A two-entry skid buffer gives full throughput under back-pressure, and a synchronous flush supports branch redirects.

## Interface
- `XLEN`, default 32: datapath width, 32 or 64; all immediates sign-extend to XLEN.
- `SIDE_W`, default 32: width of the opaque sideband (typically PC) carried alongside each instruction.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  synchronous discard of all held entries.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_side`  in  SIDE_W  sideband, passed through unchanged.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  downstream accepts.
- `out_imm`  out  XLEN  immediate.
- `out_type`  out  3  format: I=0, S=1, B=2, U=3, J=4, Z=5 (CSR zimm), N=6 (no immediate).
- `out_illegal`  out  1  opcode not recognised for this XLEN.
- `out_side`  out  SIDE_W  sideband of the same instruction.

## Operation
- Decode is purely from `instr[6:0]`, plus `funct3[2]` for SYSTEM:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111 → I.
  - SYSTEM 1110011 → Z if `funct3[2]=1`, else I.
  - STORE 0100011 → S; BRANCH 1100011 → B; LUI 0110111 and AUIPC 0010111 → U; JAL 1101111 → J; OP 0110011 → N.
  - XLEN=64 only: OP-IMM-32 0011011 → I; OP-32 0111011 → N.
  - Any other opcode, including the two 64-bit ones when XLEN=32: `out_illegal`=1, type N, imm 0.
- Immediate formation:
  - I, S, B and J follow the RISC-V layouts, sign bit `instr[31]`; B and J have bit 0 = 0.
  - U is `{instr[31:12], 12'b0}`, sign-extended from bit 31 when XLEN=64.
  - Z is `instr[19:15]`, zero-extended.
  - N is 0.
- Storage is a main output register M plus a skid register K, each with a valid bit.
- Accept occurs when `in_valid && in_ready`; the decoded result goes to M if M is empty or is being drained this cycle, otherwise to K.
- Drain occurs when `out_valid && out_ready`; if K is valid, K moves to M and K clears.
- Ordering is strict FIFO; no entry is duplicated or dropped.
- `in_ready` = !K.valid, driven from a register with no combinational path from `out_ready`.
- Flush:
  - Clears both valid bits; any accept in the same cycle is discarded.
  - `in_ready` is 1 the following cycle.
  - Flush has priority over accept and drain.
- Reset: `out_valid`=0, K.valid=0, `in_ready`=1 in the cycle after the reset edge. Data outputs are reset to 0 (imm 0, type 0, illegal 0, side 0).

## Timing
- Latency is 1 cycle: an accept at edge n gives `out_valid`=1 after edge n with the decoded data.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- With `out_ready` held at 0, M and K fill after two accepts and `in_ready` falls after the second edge. The first drain edge raises `in_ready` again.
- Payload outputs must stay stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-stream behaves identically to flush, plus it clears the data outputs. Held instructions are lost and none are emitted afterwards.
- Accept and drain in the same cycle with K empty: M is replaced and occupancy is unchanged.

## Structure
- Shared package `rv_pkg` holds:
  - enum `imm_type_e` (I..N, 3 bits);
  - opcode localparams (`OPC_LOAD` …);
  - the struct `imm_res_t` {imm, type, illegal}.
- Sub-module `imm_decode` (combinational, parameter XLEN): instruction → `imm_res_t`. It sits before M and K so both registers store decoded results.
- The top level contains only the skid/handshake control and the registers.

## Test plan
- XLEN=32, stream with `out_ready`=1 throughout; expected `out_imm` / `out_type`:
  - `0xFFF00093` (addi) → `0xFFFFFFFF` / 0
  - `0xFE112E23` (sw) → `0xFFFFFFFC` / 1
  - `0xFE000CE3` (beq) → `0xFFFFFFF8` / 2
  - `0x001000EF` (jal) → `0x00000800` / 4
  - `0x3002D073` (csrrwi) → `0x00000005` / 5
  - `0x00208033` (add) → 0 / 6
  - Each result appears exactly one cycle after its accept.
- XLEN=64: `0x800002B7` (lui) → `0xFFFFFFFF80000000`, type 3. `0x0010009B` (addiw) → 1, type 0. With XLEN=32, the same addiw gives `out_illegal`=1, imm 0.
- Back-pressure: `out_ready`=0, offer A, B, C on consecutive cycles.
  - `in_ready` drops after B; C is held upstream.
  - Raise `out_ready`: outputs are A, B, C in order on consecutive cycles, with `out_side` matching.
- Flush with M and K both full while `in_valid`=1: next cycle `out_valid`=0, `in_ready`=1, and the flushed and concurrent inputs never appear.
- Reset mid-stream (M full, `out_ready`=0): after the edge, all outputs are 0, `in_ready`=1, and a new accept emits only the new instruction.
- Randomised valid/ready toggling over 10k instructions against a reference queue: no loss, duplication or reordering, and the payload stays stable while stalled.

Source files
------------

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared immediate-format types and opcode constants for the decode path
package rv_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5,
        IMM_N = 3'd6
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Immediates are always formed at the widest XLEN; narrower stages keep the low bits.
    localparam int XLEN_MAX = 64;

    typedef struct packed {
        logic [XLEN_MAX-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
    } imm_res_t;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational opcode classification and immediate formation
module imm_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0] instr_i,
    output imm_res_t    res_o
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]          opcode;
    logic [XLEN_MAX-1:0] imm_i;
    logic [XLEN_MAX-1:0] imm_s;
    logic [XLEN_MAX-1:0] imm_b;
    logic [XLEN_MAX-1:0] imm_u;
    logic [XLEN_MAX-1:0] imm_j;
    logic [XLEN_MAX-1:0] imm_z;

    assign opcode = instr_i[6:0];
    assign imm_i  = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{51{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
    assign imm_j  = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_z  = {59'b0, instr_i[19:15]};

    always_comb begin
        res_o          = '0;
        res_o.imm_type = IMM_N;
        res_o.illegal  = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: res_o.imm_type = IMM_I;
            OPC_SYSTEM:     res_o.imm_type = instr_i[14] ? IMM_Z : IMM_I;
            OPC_STORE:      res_o.imm_type = IMM_S;
            OPC_BRANCH:     res_o.imm_type = IMM_B;
            OPC_LUI, OPC_AUIPC: res_o.imm_type = IMM_U;
            OPC_JAL:        res_o.imm_type = IMM_J;
            OPC_OP:         res_o.imm_type = IMM_N;
            OPC_OP_IMM_32: begin
                if (RV64) res_o.imm_type = IMM_I;
                else      res_o.illegal  = 1'b1;
            end
            OPC_OP_32: begin
                if (!RV64) res_o.illegal = 1'b1;
            end
            default:        res_o.illegal = 1'b1;
        endcase

        case (res_o.imm_type)
            IMM_I:   res_o.imm = imm_i;
            IMM_S:   res_o.imm = imm_s;
            IMM_B:   res_o.imm = imm_b;
            IMM_U:   res_o.imm = imm_u;
            IMM_J:   res_o.imm = imm_j;
            IMM_Z:   res_o.imm = imm_z;
            default: res_o.imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator stage with two-entry skid buffer
module imm_gen_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_imm,
    output logic [2:0]        out_type,
    output logic              out_illegal,
    output logic [SIDE_W-1:0] out_side
);

    imm_res_t dec_res;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i (in_instr),
        .res_o   (dec_res)
    );

    if (XLEN < XLEN_MAX) begin : g_imm_hi
        logic imm_hi_unused;
        assign imm_hi_unused = ^dec_res.imm[XLEN_MAX-1:XLEN];
    end

    logic              m_valid_q, m_valid_d;
    logic [XLEN-1:0]   m_imm_q,   m_imm_d;
    imm_type_e         m_type_q,  m_type_d;
    logic              m_ill_q,   m_ill_d;
    logic [SIDE_W-1:0] m_side_q,  m_side_d;

    logic              k_valid_q, k_valid_d;
    logic [XLEN-1:0]   k_imm_q,   k_imm_d;
    imm_type_e         k_type_q,  k_type_d;
    logic              k_ill_q,   k_ill_d;
    logic [SIDE_W-1:0] k_side_q,  k_side_d;

    logic in_ready_q, in_ready_d;
    logic accept, drain;

    assign accept = in_valid && in_ready_q;
    assign drain  = m_valid_q && out_ready;

    // in_ready_q mirrors !k_valid_q, so an accept never coincides with a full skid entry.
    always_comb begin
        m_valid_d = m_valid_q;
        m_imm_d   = m_imm_q;
        m_type_d  = m_type_q;
        m_ill_d   = m_ill_q;
        m_side_d  = m_side_q;
        k_valid_d = k_valid_q;
        k_imm_d   = k_imm_q;
        k_type_d  = k_type_q;
        k_ill_d   = k_ill_q;
        k_side_d  = k_side_q;

        if (flush) begin
            m_valid_d = 1'b0;
            k_valid_d = 1'b0;
        end else if (drain) begin
            if (k_valid_q) begin
                m_valid_d = 1'b1;
                m_imm_d   = k_imm_q;
                m_type_d  = k_type_q;
                m_ill_d   = k_ill_q;
                m_side_d  = k_side_q;
                k_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_imm_d   = dec_res.imm[XLEN-1:0];
                m_type_d  = dec_res.imm_type;
                m_ill_d   = dec_res.illegal;
                m_side_d  = in_side;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_valid_d = 1'b1;
                m_imm_d   = dec_res.imm[XLEN-1:0];
                m_type_d  = dec_res.imm_type;
                m_ill_d   = dec_res.illegal;
                m_side_d  = in_side;
            end else begin
                k_valid_d = 1'b1;
                k_imm_d   = dec_res.imm[XLEN-1:0];
                k_type_d  = dec_res.imm_type;
                k_ill_d   = dec_res.illegal;
                k_side_d  = in_side;
            end
        end

        in_ready_d = !k_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            m_imm_q    <= '0;
            m_type_q   <= IMM_I;
            m_ill_q    <= 1'b0;
            m_side_q   <= '0;
            k_valid_q  <= 1'b0;
            k_imm_q    <= '0;
            k_type_q   <= IMM_I;
            k_ill_q    <= 1'b0;
            k_side_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            m_valid_q  <= m_valid_d;
            m_imm_q    <= m_imm_d;
            m_type_q   <= m_type_d;
            m_ill_q    <= m_ill_d;
            m_side_q   <= m_side_d;
            k_valid_q  <= k_valid_d;
            k_imm_q    <= k_imm_d;
            k_type_q   <= k_type_d;
            k_ill_q    <= k_ill_d;
            k_side_q   <= k_side_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = m_valid_q;
    assign out_imm     = m_imm_q;
    assign out_type    = m_type_q;
    assign out_illegal = m_ill_q;
    assign out_side    = m_side_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed and randomized checks of imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_side;

    logic        r32, v32, ill32;
    logic [31:0] imm32, side32;
    logic [2:0]  t32;
    logic        r64, v64, ill64;
    logic [63:0] imm64;
    logic [31:0] side64;
    logic [2:0]  t64;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .SIDE_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_side(in_side),
        .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_type(t32),
        .out_illegal(ill32), .out_side(side32)
    );

    imm_gen_stage #(.XLEN(64), .SIDE_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_side(in_side),
        .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_type(t64),
        .out_illegal(ill64), .out_side(side64)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] side;
    } ent_t;

    ent_t        q[$];
    int          n_pass = 0, n_fail = 0, n_total = 0;
    int          n_acc = 0;
    bit          mon_en = 1'b0;
    bit          stall_prev = 1'b0;
    bit          last_acc = 1'b0;
    logic [31:0] sv_imm32, sv_side;
    logic [63:0] sv_imm64;

    logic [31:0] st_ins [6] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                                32'h001000EF, 32'h3002D073, 32'h00208033};
    logic [31:0] st_imm [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'h00000800, 32'h00000005, 32'h00000000};
    logic [2:0]  st_typ [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    logic [6:0]  ops [13]   = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63,
                                7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B, 7'h3B};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the RISC-V immediate rules written as shifts of the sign-extended word.
    function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                    output logic [63:0] imm, output logic [2:0] typ,
                                    output logic ill);
        longint s, sx20, sx25, sgn;
        int     t;
        s    = longint'($signed(ins));
        sx20 = s >>> 20;
        sx25 = s >>> 25;
        sgn  = s >>> 63;
        ill  = 1'b0;
        t    = 6;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h0F: t = 0;
            7'h73: t = ins[14] ? 5 : 0;
            7'h23: t = 1;
            7'h63: t = 2;
            7'h37, 7'h17: t = 3;
            7'h6F: t = 4;
            7'h33: t = 6;
            7'h1B: if (xlen == 64) t = 0; else ill = 1'b1;
            7'h3B: if (xlen != 64) ill = 1'b1;
            default: ill = 1'b1;
        endcase
        case (t)
            0: imm = sx20;
            1: imm = (sx25 << 5) | longint'(ins[11:7]);
            2: imm = (sgn << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5)
                     | (longint'(ins[11:8]) << 1);
            3: imm = longint'($signed(ins & 32'hFFFFF000));
            4: imm = (sgn << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11)
                     | (longint'(ins[30:21]) << 1);
            5: imm = longint'(ins[19:15]);
            default: imm = 64'd0;
        endcase
        if (xlen == 32) imm[63:32] = 32'd0;
        typ = 3'(t);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 3) != 0) r[6:0] = ops[$urandom_range(0, 12)];
        return r;
    endfunction

    task automatic tick();
        logic [63:0] ei;
        logic [2:0]  et;
        logic        el;
        bit          acc, drn;
        @(negedge clk);
        if (mon_en) begin
            chk("out_valid32", v32, q.size() != 0);
            chk("out_valid64", v64, q.size() != 0);
            chk("in_ready32", r32, q.size() < 2);
            chk("in_ready64", r64, q.size() < 2);
            if (q.size() != 0) begin
                ref_dec(q[0].instr, 32, ei, et, el);
                chk("imm32", imm32, ei[31:0]);
                chk("type32", t32, et);
                chk("ill32", ill32, el);
                chk("side32", side32, q[0].side);
                ref_dec(q[0].instr, 64, ei, et, el);
                chk("imm64", imm64, ei);
                chk("type64", t64, et);
                chk("ill64", ill64, el);
                chk("side64", side64, q[0].side);
            end
            if (stall_prev) begin
                chk("stable_imm32", imm32, sv_imm32);
                chk("stable_imm64", imm64, sv_imm64);
                chk("stable_side", side32, sv_side);
            end
            stall_prev = 1'b0;
            acc = in_valid && (q.size() < 2);
            drn = (q.size() != 0) && out_ready;
            if (rst || flush) begin
                q.delete();
                acc = 1'b0;
            end else begin
                if (q.size() != 0 && !out_ready) begin
                    stall_prev = 1'b1;
                    sv_imm32   = imm32;
                    sv_imm64   = imm64;
                    sv_side    = side32;
                end
                if (drn) void'(q.pop_front());
                if (acc) begin
                    q.push_back('{in_instr, in_side});
                    n_acc++;
                end
            end
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'd0; in_side = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("rst_valid", v32, 1'b0);
        chk("rst_ready", r32, 1'b1);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_type", t32, 3'd0);
        chk("rst_side", side32, 32'd0);
        rst = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = st_ins[i]; in_side = 32'h100 + 32'(i * 4);
            tick();
            chk("stream_valid", v32, 1'b1);
            chk("stream_imm", imm32, st_imm[i]);
            chk("stream_type", t32, st_typ[i]);
        end
        in_valid = 1'b0;
        tick();

        in_valid = 1'b1; in_instr = 32'h800002B7; in_side = 32'h200;
        tick();
        chk("lui64_imm", imm64, 64'hFFFFFFFF80000000);
        chk("lui64_type", t64, 3'd3);
        in_instr = 32'h0010009B;
        tick();
        chk("addiw64_imm", imm64, 64'd1);
        chk("addiw64_type", t64, 3'd0);
        chk("addiw64_ill", ill64, 1'b0);
        chk("addiw32_ill", ill32, 1'b1);
        chk("addiw32_imm", imm32, 32'd0);
        in_valid = 1'b0;
        tick();

        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_side = 32'hA0;
        tick();
        chk("bp_ready_a", r32, 1'b1);
        in_instr = 32'h00A00113; in_side = 32'hB0;
        tick();
        chk("bp_ready_b", r32, 1'b0);
        in_instr = 32'h00F00193; in_side = 32'hC0;
        tick();
        chk("bp_ready_c", r32, 1'b0);
        chk("bp_out_a", side32, 32'hA0);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", side32, 32'hB0);
        chk("bp_ready_drain", r32, 1'b1);
        tick();
        chk("bp_out_c", side32, 32'hC0);
        chk("bp_imm_c", imm32, 32'd15);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", v32, 1'b0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_side = 32'hF1;
        tick();
        in_instr = 32'h00200093; in_side = 32'hF2;
        tick();
        in_instr = 32'h00300093; in_side = 32'hF3; flush = 1'b1;
        tick();
        chk("flush_valid", v32, 1'b0);
        chk("flush_ready", r32, 1'b1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_nothing", v32, 1'b0);

        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFE112E23; in_side = 32'hDEAD;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        chk("mrst_valid", v64, 1'b0);
        chk("mrst_ready", r64, 1'b1);
        chk("mrst_imm", imm32, 32'd0);
        chk("mrst_type", t32, 3'd0);
        chk("mrst_ill", ill64, 1'b0);
        chk("mrst_side", side32, 32'd0);
        rst = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00700093; in_side = 32'hE0;
        tick();
        chk("mrst_new_side", side32, 32'hE0);
        chk("mrst_new_imm", imm32, 32'd7);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("mrst_drained", v32, 1'b0);

        n_acc = 0;
        for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_instr = rand_instr();
                in_side  = $urandom;
            end
            out_ready = ($urandom_range(0, 99) < 65);
            flush     = ($urandom_range(0, 999) < 5);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("rand_final_empty", v32, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
